// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_e;

    // Width of a requester index; at least one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus: per-requester request/operands in, grant/done/result out.
interface mul_share_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) ();

    logic [N_REQ-1:0]            req_i;
    logic [N_REQ-1:0][OP_W-1:0]  a_i;
    logic [N_REQ-1:0][OP_W-1:0]  b_i;
    logic [N_REQ-1:0]            gnt_o;
    logic [N_REQ-1:0]            done_o;
    logic                        err_o;
    logic [RES_W-1:0]            result_o;

    modport master (
        output req_i, a_i, b_i,
        input  gnt_o, done_o, err_o, result_o
    );

    modport slave (
        input  req_i, a_i, b_i,
        output gnt_o, done_o, err_o, result_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request above the pointer.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_c_o,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             valid_c_o
);

    logic [IDX_W-1:0] cand;

    // Scan ptr+1, ptr+2, ... wrapping modulo N_REQ; the first hit wins.
    always_comb begin
        gnt_c_o   = '0;
        idx_c_o   = '0;
        valid_c_o = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
            if (!valid_c_o && req_i[cand]) begin
                valid_c_o     = 1'b1;
                idx_c_o       = cand;
                gnt_c_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential 4x4 multiplier between N_REQ requesters, round-robin.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mul_share_arbiter_if.slave req_if,
    output logic               busy_o,
    output logic               mul_start_o,
    output logic [OP_W-1:0]    mul_a_o,
    output logic [OP_W-1:0]    mul_b_o,
    input  logic               mul_busy_i,
    input  logic               mul_valid_i,
    input  logic [RES_W-1:0]   mul_result_i
);

    localparam int unsigned IDX_W = idx_w(N_REQ);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [N_REQ-1:0]   sel_q,    sel_d;
    logic [IDX_W-1:0]   ptr_q,    ptr_d;
    logic [OP_W-1:0]    op_a_q,   op_a_d;
    logic [OP_W-1:0]    op_b_q,   op_b_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               err_q,    err_d;
    logic [N_REQ-1:0]   gnt_q,    gnt_d;
    logic [N_REQ-1:0]   done_q,   done_d;
    logic               busy_q,   busy_d;
    logic               start_q,  start_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i     (req_if.req_i),
        .ptr_i     (ptr_q),
        .gnt_c_o   (pick_gnt),
        .idx_c_o   (pick_idx),
        .valid_c_o (pick_valid)
    );

    // Next-state logic; outputs are precomputed from the next state so they register in step.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        cnt_d    = cnt_q;
        result_d = '0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    sel_d   = pick_gnt;
                    op_a_d  = req_if.a_i[pick_idx];
                    op_b_d  = req_if.b_i[pick_idx];
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Valid only counts once the multiplier has left CALC.
                if (mul_valid_i && !mul_busy_i) begin
                    result_d = mul_result_i;
                    state_d  = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
        gnt_d   = busy_d ? sel_d : '0;
        done_d  = (state_d == RESP) ? sel_d : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            sel_q    <= '0;
            ptr_q    <= IDX_W'(N_REQ - 1);
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
        end
    end

    assign req_if.gnt_o    = gnt_q;
    assign req_if.done_o   = done_q;
    assign req_if.err_o    = err_q;
    assign req_if.result_o = result_q;
    assign busy_o          = busy_q;
    assign mul_start_o     = start_q;
    assign mul_a_o         = op_a_q;
    assign mul_b_o         = op_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter with a bit-serial shift-add multiplier model attached.
module tb_mul_share_arbiter;

    localparam int unsigned N = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    mul_share_arbiter_if #(.N_REQ(N)) rif ();

    logic       busy_o, mul_start_o;
    logic [3:0] mul_a_o, mul_b_o;
    logic       mul_busy_i, mul_valid_i;
    logic [7:0] mul_result_i;

    int total = 0;
    int bad   = 0;

    mul_share_arbiter #(.N_REQ(N), .TIMEOUT(15)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_if       (rif),
        .busy_o       (busy_o),
        .mul_start_o  (mul_start_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_busy_i   (mul_busy_i),
        .mul_valid_i  (mul_valid_i),
        .mul_result_i (mul_result_i)
    );

    // Multiplier model: 4 CALC cycles sampling A one bit per cycle, then DONE held until next start.
    logic       mul_dead = 1'b0;
    logic [7:0] acc;
    logic [3:0] mb;
    logic [1:0] bitn;
    logic [7:0] acc_n;
    assign acc_n = acc + (mul_a_o[bitn] ? (8'(mb) << bitn) : 8'd0);

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_busy_i <= 1'b0; mul_valid_i <= 1'b0; mul_result_i <= 8'd0;
            acc <= 8'd0; mb <= 4'd0; bitn <= 2'd0;
        end else if (mul_dead) begin
            mul_busy_i <= 1'b0; mul_valid_i <= 1'b0;
        end else if (mul_start_o) begin
            mul_busy_i <= 1'b1; mul_valid_i <= 1'b0;
            acc <= 8'd0; mb <= mul_b_o; bitn <= 2'd0;
        end else if (mul_busy_i) begin
            acc  <= acc_n;
            bitn <= bitn + 2'd1;
            if (bitn == 2'd3) begin
                mul_busy_i   <= 1'b0;
                mul_valid_i  <= 1'b1;
                mul_result_i <= acc_n;
            end
        end
    end

    // Round-robin reference: first requester after the last winner, wrapping.
    function automatic int rr_winner(input logic [3:0] r, input int last);
        int j;
        for (int k = 1; k <= 4; k++) begin
            j = (last + k) % 4;
            if (r[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        rif.req_i = '0; rif.a_i = '0; rif.b_i = '0;
        @(negedge clk_i);
        total++;
        if ({rif.gnt_o, rif.done_o} !== 8'h00) begin
            bad++; $display("FAIL reset_gnt_done got=%b/%b exp=0/0", rif.gnt_o, rif.done_o);
        end
        total++;
        if ({rif.err_o, rif.result_o, busy_o, mul_start_o} !== 11'h0) begin
            bad++; $display("FAIL reset_flags err=%b res=%0d busy=%b start=%b exp all 0",
                            rif.err_o, rif.result_o, busy_o, mul_start_o);
        end
        total++;
        if ({mul_a_o, mul_b_o} !== 8'h00) begin
            bad++; $display("FAIL reset_operands got a=%0d b=%0d exp 0", mul_a_o, mul_b_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || rif.gnt_o !== 4'b0) begin
            bad++; $display("FAIL reset_idle busy=%b gnt=%b exp 0", busy_o, rif.gnt_o);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_g, exp_d;
        rif.req_i = 4'b0001; rif.a_i[0] = 4'd7; rif.b_i[0] = 4'd9;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            exp_g = (c <= 7) ? 4'b0001 : 4'b0000;
            exp_d = (c == 7) ? 4'b0001 : 4'b0000;
            total++;
            if (rif.gnt_o !== exp_g) begin
                bad++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, rif.gnt_o, exp_g);
            end
            total++;
            if (mul_start_o !== (c == 1)) begin
                bad++; $display("FAIL single_start c=%0d got=%b exp=%b", c, mul_start_o, (c == 1));
            end
            total++;
            if (rif.done_o !== exp_d) begin
                bad++; $display("FAIL single_done c=%0d got=%b exp=%b", c, rif.done_o, exp_d);
            end
            if (c == 7) begin
                total++;
                if (rif.result_o !== 8'd63 || rif.err_o !== 1'b0) begin
                    bad++; $display("FAIL single_result got=%0d err=%b exp=63 err=0", rif.result_o, rif.err_o);
                end
                rif.req_i = '0;
            end
        end
    endtask

    task automatic test_contention();
        int ord [6];
        int n;
        ord = '{0, 1, 3, 0, 1, 3};
        n = 0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        rif.req_i = 4'b1011;
        for (int i = 0; i < 4; i++) begin rif.a_i[i] = 4'd15; rif.b_i[i] = 4'd15; end
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk_i);
            if (rif.done_o != 4'b0) begin
                total++;
                if (n >= 6 || rif.done_o !== 4'(1 << ord[n]) || rif.result_o !== 8'd225 ||
                    rif.err_o !== 1'b0 || c != 7 + 8 * n) begin
                    bad++; $display("FAIL contention_done n=%0d c=%0d got=%b res=%0d err=%b exp=%b res=225 c=%0d",
                                    n, c, rif.done_o, rif.result_o, rif.err_o,
                                    (n < 6) ? 4'(1 << ord[n]) : 4'b0, 7 + 8 * n);
                end
                n++;
                if (n == 6) rif.req_i = '0;
            end
        end
        total++;
        if (n != 6) begin
            bad++; $display("FAIL contention_count got=%0d exp=6", n);
        end
    endtask

    task automatic test_operand_stability();
        logic [3:0] exp_d;
        rif.req_i = 4'b0100; rif.a_i[2] = 4'd5; rif.b_i[2] = 4'd3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            exp_d = (c == 7) ? 4'b0100 : 4'b0000;
            if (c >= 2 && c <= 6) begin
                total++;
                if (mul_a_o !== 4'd5 || mul_b_o !== 4'd3) begin
                    bad++; $display("FAIL stable_operands c=%0d got a=%0d b=%0d exp a=5 b=3", c, mul_a_o, mul_b_o);
                end
            end
            total++;
            if (rif.done_o !== exp_d) begin
                bad++; $display("FAIL stable_done c=%0d got=%b exp=%b", c, rif.done_o, exp_d);
            end
            if (c == 2) rif.a_i[2] = 4'd15;
            if (c == 7) begin
                total++;
                if (rif.result_o !== 8'd15 || rif.err_o !== 1'b0) begin
                    bad++; $display("FAIL stable_result got=%0d err=%b exp=15 err=0", rif.result_o, rif.err_o);
                end
                rif.req_i = '0;
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_d;
        mul_dead = 1'b1;
        rif.req_i = 4'b0010; rif.a_i[1] = 4'd3; rif.b_i[1] = 4'd4;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk_i);
            exp_d = (c == 18) ? 4'b0010 : 4'b0000;
            total++;
            if (rif.done_o !== exp_d) begin
                bad++; $display("FAIL timeout_done c=%0d got=%b exp=%b", c, rif.done_o, exp_d);
            end
            if (c == 17) begin
                total++;
                if (rif.gnt_o !== 4'b0010) begin
                    bad++; $display("FAIL timeout_gnt got=%b exp=0010", rif.gnt_o);
                end
            end
            if (c == 18) begin
                total++;
                if (rif.err_o !== 1'b1 || rif.result_o !== 8'd0) begin
                    bad++; $display("FAIL timeout_err got err=%b res=%0d exp err=1 res=0", rif.err_o, rif.result_o);
                end
                rif.req_i = '0;
                mul_dead  = 1'b0;
            end
        end
        rif.req_i = 4'b0010; rif.a_i[1] = 4'd2; rif.b_i[1] = 4'd3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (c == 7) begin
                total++;
                if (rif.done_o !== 4'b0010 || rif.result_o !== 8'd6 || rif.err_o !== 1'b0) begin
                    bad++; $display("FAIL timeout_recover got done=%b res=%0d err=%b exp 0010/6/0",
                                    rif.done_o, rif.result_o, rif.err_o);
                end
                rif.req_i = '0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_d;
        int ndone;
        ndone = 0;
        rif.req_i = 4'b0001; rif.a_i[0] = 4'd0; rif.b_i[0] = 4'd12;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            exp_d = (c == 7 || c == 15) ? 4'b0001 : 4'b0000;
            if (rif.done_o != 4'b0) ndone++;
            total++;
            if (rif.done_o !== exp_d) begin
                bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, rif.done_o, exp_d);
            end
            if (c == 7) begin
                total++;
                if (rif.result_o !== 8'd0) begin
                    bad++; $display("FAIL b2b_first got=%0d exp=0", rif.result_o);
                end
                rif.a_i[0] = 4'd1; rif.b_i[0] = 4'd1;
            end
            if (c == 15) begin
                total++;
                if (rif.result_o !== 8'd1) begin
                    bad++; $display("FAIL b2b_second got=%0d exp=1", rif.result_o);
                end
                rif.req_i = '0;
            end
        end
        total++;
        if (ndone != 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", ndone);
        end
    endtask

    task automatic test_reset_midop();
        logic [3:0] exp_d;
        rif.req_i = 4'b1000; rif.a_i[3] = 4'd6; rif.b_i[3] = 4'd7;
        for (int c = 1; c <= 3; c++) @(negedge clk_i);
        rst_ni = 1'b0;
        rif.req_i = '0;
        #1;
        total++;
        if ({rif.gnt_o, rif.done_o, busy_o, mul_start_o} !== 10'h0) begin
            bad++; $display("FAIL midrst_ctrl gnt=%b done=%b busy=%b start=%b exp all 0",
                            rif.gnt_o, rif.done_o, busy_o, mul_start_o);
        end
        total++;
        if ({mul_a_o, mul_b_o, rif.result_o, rif.err_o} !== 17'h0) begin
            bad++; $display("FAIL midrst_data a=%0d b=%0d res=%0d err=%b exp all 0",
                            mul_a_o, mul_b_o, rif.result_o, rif.err_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        rif.req_i = 4'b0101;
        rif.a_i[0] = 4'd2; rif.b_i[0] = 4'd5; rif.a_i[2] = 4'd3; rif.b_i[2] = 4'd3;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk_i);
            exp_d = (c == 7) ? 4'b0001 : (c == 15) ? 4'b0100 : 4'b0000;
            total++;
            if (rif.done_o !== exp_d) begin
                bad++; $display("FAIL midrst_done c=%0d got=%b exp=%b", c, rif.done_o, exp_d);
            end
            if (c == 1) begin
                total++;
                if (rif.gnt_o !== 4'b0001) begin
                    bad++; $display("FAIL midrst_ptr got=%b exp=0001", rif.gnt_o);
                end
            end
            if (c == 7) begin
                total++;
                if (rif.result_o !== 8'd10) begin
                    bad++; $display("FAIL midrst_res0 got=%0d exp=10", rif.result_o);
                end
                rif.req_i[0] = 1'b0;
            end
            if (c == 15) begin
                total++;
                if (rif.result_o !== 8'd9) begin
                    bad++; $display("FAIL midrst_res2 got=%0d exp=9", rif.result_o);
                end
                rif.req_i[2] = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] pend, prev_req, prev_g, g, d;
        logic [3:0] pa [4];
        logic [3:0] pb [4];
        int  last_w, cur_w, w, start_c, ops, exp_prod;
        bit  active, rose;
        rst_ni = 1'b0;
        rif.req_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        pend = '0; prev_req = '0; prev_g = '0;
        last_w = N - 1; cur_w = 0; start_c = 0; ops = 0; exp_prod = 0; active = 1'b0;
        for (int i = 0; i < 4; i++) begin pa[i] = rif.a_i[i]; pb[i] = rif.b_i[i]; end
        for (int c = 1; c <= 420; c++) begin
            @(negedge clk_i);
            g = rif.gnt_o; d = rif.done_o;
            rose = (g != 4'b0) && (prev_g == 4'b0);
            if (rose) begin
                w = rr_winner(prev_req, last_w);
                total++;
                if (w < 0 || g !== 4'(1 << w)) begin
                    bad++; $display("FAIL rand_grant c=%0d got=%b exp_idx=%0d req=%b", c, g, w, prev_req);
                end else begin
                    active = 1'b1; cur_w = w; start_c = c;
                    exp_prod = int'(pa[w]) * int'(pb[w]);
                end
            end
            if (d != 4'b0) begin
                total++;
                if (!active || d !== g || c - start_c != 6 || int'(rif.result_o) != exp_prod || rif.err_o !== 1'b0) begin
                    bad++; $display("FAIL rand_done c=%0d got=%b res=%0d err=%b lat=%0d exp=%b res=%0d lat=6",
                                    c, d, rif.result_o, rif.err_o, c - start_c, 4'(1 << cur_w), exp_prod);
                end
                last_w = cur_w; active = 1'b0; ops++;
            end else if (active && c - start_c >= 6) begin
                total++; bad++;
                $display("FAIL rand_latency c=%0d no done after %0d cycles exp 6", c, c - start_c);
                last_w = cur_w; active = 1'b0;
            end
            prev_g = g;
            for (int i = 0; i < 4; i++) begin
                if (d[i]) begin pend[i] = 1'b0; rif.req_i[i] = 1'b0; end
            end
            if (rose && active) begin
                rif.a_i[cur_w] = 4'($urandom_range(0, 15));
                rif.b_i[cur_w] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) begin pend[cur_w] = 1'b0; rif.req_i[cur_w] = 1'b0; end
            end
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && !d[i] && c <= 360 && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1; rif.req_i[i] = 1'b1;
                    rif.a_i[i] = 4'($urandom_range(0, 15));
                    rif.b_i[i] = 4'($urandom_range(0, 15));
                end
            end
            prev_req = rif.req_i;
            for (int i = 0; i < 4; i++) begin pa[i] = rif.a_i[i]; pb[i] = rif.b_i[i]; end
        end
        total++;
        if (ops < 20 || active || pend != 4'b0) begin
            bad++; $display("FAIL rand_summary ops=%0d active=%b pend=%b exp ops>=20 idle", ops, active, pend);
        end
        rif.req_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_operand_stability();
        test_timeout();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
